// File: rtl/lexington.sv
// Shared interrupt types and trap cause codes for the machine-mode interrupt controller.
package lexington;

   localparam int unsigned NUM_PLAT_IRQ   = 10;
   localparam int unsigned IRQ_CODE_WIDTH = 5;
   localparam int unsigned CSR_WIDTH      = 32;
   localparam int unsigned PLAT_LSB       = 16;
   localparam int unsigned PLAT_MSB       = PLAT_LSB + NUM_PLAT_IRQ - 1;

   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_MSI     = 5'd3;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_MTI     = 5'd7;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_MEI     = 5'd11;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_UART0RX = 5'd16;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_UART0TX = 5'd17;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_TIM0    = 5'd18;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_TIM1    = 5'd19;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_GPIOA0  = 5'd20;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_GPIOA1  = 5'd21;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_GPIOB0  = 5'd22;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_GPIOB1  = 5'd23;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_GPIOC0  = 5'd24;
   localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_GPIOC1  = 5'd25;

   // mie/mip layout; reserved and supervisor fields are never set by this block
   typedef struct packed {
      logic [5:0]              rsvd_31_26;
      logic [NUM_PLAT_IRQ-1:0] plat;
      logic [3:0]              rsvd_15_12;
      logic                    mei;
      logic                    rsvd_10;
      logic                    sei;
      logic                    rsvd_8;
      logic                    mti;
      logic                    rsvd_6;
      logic                    sti;
      logic                    rsvd_4;
      logic                    msi;
      logic                    rsvd_2;
      logic                    ssi;
      logic                    rsvd_0;
   } interrupt_csr_t;

   typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_HOLD} irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: MEI, MSI, MTI, then platform codes with the lowest code winning.
module irq_prio_enc
   import lexington::*;
(
   input  logic [CSR_WIDTH-1:0]      eligible,
   output logic                      valid_c,
   output logic [IRQ_CODE_WIDTH-1:0] code_c
);

   logic [NUM_PLAT_IRQ-1:0] plat_c;
   logic                    unused_c;

   assign plat_c   = eligible[PLAT_MSB:PLAT_LSB];
   assign unused_c = ^{eligible[CSR_WIDTH-1:PLAT_MSB+1], eligible[PLAT_LSB-1:12],
                       eligible[10:8], eligible[6:4], eligible[2:0]};

   always_comb begin
      valid_c = 1'b0;
      code_c  = '0;
      // scan downwards so the lowest set platform code is the one left standing
      for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
         if (plat_c[4'(i)]) begin
            valid_c = 1'b1;
            code_c  = IRQ_CODE_WIDTH'(PLAT_LSB + 32'(i));
         end
      end
      if (eligible[7]) begin
         valid_c = 1'b1;
         code_c  = TRAP_CODE_MTI;
      end
      if (eligible[3]) begin
         valid_c = 1'b1;
         code_c  = TRAP_CODE_MSI;
      end
      if (eligible[11]) begin
         valid_c = 1'b1;
         code_c  = TRAP_CODE_MEI;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt scheduler: pending image, masking, priority select and trap handshake.
// Define IRQ_CTRL_EDGE_EN to latch platform lines on rising edges instead of sampling levels.
module irq_ctrl
   import lexington::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      meip,
   input  logic                      msip,
   input  logic                      mtip,
   input  logic [NUM_PLAT_IRQ-1:0]   plat_irq,
   input  logic                      mstatus_mie,
   input  logic [CSR_WIDTH-1:0]      mie,
   input  logic                      mip_clr,
   input  logic [CSR_WIDTH-1:0]      mip_clr_mask,
   output logic [CSR_WIDTH-1:0]      mip,
   output logic                      trap_req,
   output logic [IRQ_CODE_WIDTH-1:0] trap_code,
   input  logic                      trap_ack
);

   irq_state_t                  state_q, state_d;
   logic                        trap_req_q, trap_req_d;
   logic [IRQ_CODE_WIDTH-1:0]   trap_code_q, trap_code_d;
   logic                        mei_q, msi_q, mti_q;
   logic [NUM_PLAT_IRQ-1:0]     plat_q, plat_d;
   interrupt_csr_t              mip_c;
   logic [CSR_WIDTH-1:0]        eligible_c;
   logic                        prio_valid_c;
   logic [IRQ_CODE_WIDTH-1:0]   prio_code_c;
   logic                        unused_c;

   always_comb begin
      mip_c      = '0;
      mip_c.mei  = mei_q;
      mip_c.msi  = msi_q;
      mip_c.mti  = mti_q;
      mip_c.plat = plat_q;
   end

   assign mip        = mip_c;
   assign trap_req   = trap_req_q;
   assign trap_code  = trap_code_q;
   assign eligible_c = mip_c & mie & {CSR_WIDTH{mstatus_mie}};

   irq_prio_enc u_prio_enc (
      .eligible (eligible_c),
      .valid_c  (prio_valid_c),
      .code_c   (prio_code_c)
   );

`ifdef IRQ_CTRL_EDGE_EN
   logic [NUM_PLAT_IRQ-1:0] hist_q, hist_d;
   logic [NUM_PLAT_IRQ-1:0] clr_c;

   // a new edge is OR-ed in after clearing so a same-cycle set is never lost
   always_comb begin
      hist_d = plat_irq;
      clr_c  = mip_clr ? mip_clr_mask[PLAT_MSB:PLAT_LSB] : '0;
      for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
         if (state_q == IRQ_REQ && trap_ack &&
             trap_code_q == IRQ_CODE_WIDTH'(PLAT_LSB + 32'(i)))
            clr_c[4'(i)] = 1'b1;
      end
      plat_d = (plat_q & ~clr_c) | (plat_irq & ~hist_q);
   end

   always_ff @(posedge clk) begin
      if (rst) hist_q <= '0;
      else     hist_q <= hist_d;
   end

   assign unused_c = ^{mip_clr_mask[CSR_WIDTH-1:PLAT_MSB+1], mip_clr_mask[PLAT_LSB-1:0]};
`else
   assign plat_d   = plat_irq;
   assign unused_c = ^{mip_clr, mip_clr_mask};
`endif

   always_comb begin
      state_d     = state_q;
      trap_req_d  = trap_req_q;
      trap_code_d = trap_code_q;
      case (state_q)
         IRQ_IDLE: begin
            if (prio_valid_c) begin
               trap_code_d = prio_code_c;
               trap_req_d  = 1'b1;
               state_d     = IRQ_REQ;
            end
         end
         IRQ_REQ: begin
            // ack beats withdrawal; no preemption while the request is outstanding
            if (trap_ack) begin
               trap_req_d = 1'b0;
               state_d    = IRQ_HOLD;
            end else if (!eligible_c[trap_code_q]) begin
               trap_req_d = 1'b0;
               state_d    = IRQ_IDLE;
            end
         end
         IRQ_HOLD: state_d = IRQ_IDLE;
         default: begin
            trap_req_d = 1'b0;
            state_d    = IRQ_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IRQ_IDLE;
         trap_req_q  <= 1'b0;
         trap_code_q <= '0;
         mei_q       <= 1'b0;
         msi_q       <= 1'b0;
         mti_q       <= 1'b0;
         plat_q      <= '0;
      end else begin
         state_q     <= state_d;
         trap_req_q  <= trap_req_d;
         trap_code_q <= trap_code_d;
         mei_q       <= meip;
         msi_q       <= msip;
         mti_q       <= mtip;
         plat_q      <= plat_d;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; expectations follow IRQ_CTRL_EDGE_EN when it is defined.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        meip, msip, mtip;
   logic [9:0]  plat_irq;
   logic        mstatus_mie;
   logic [31:0] mie;
   logic        mip_clr;
   logic [31:0] mip_clr_mask;
   logic [31:0] mip;
   logic        trap_req;
   logic [4:0]  trap_code;
   logic        trap_ack;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   irq_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .meip         (meip),
      .msip         (msip),
      .mtip         (mtip),
      .plat_irq     (plat_irq),
      .mstatus_mie  (mstatus_mie),
      .mie          (mie),
      .mip_clr      (mip_clr),
      .mip_clr_mask (mip_clr_mask),
      .mip          (mip),
      .trap_req     (trap_req),
      .trap_code    (trap_code),
      .trap_ack     (trap_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1; meip = 1'b0; msip = 1'b0; mtip = 1'b0; plat_irq = '0;
      mstatus_mie = 1'b0; mie = '0; mip_clr = 1'b0; mip_clr_mask = '0; trap_ack = 1'b0;
      tick(); tick();
      chk("rst_mip", mip, 32'h0);
      chk("rst_req", 32'(trap_req), 32'h0);
      chk("rst_code", 32'(trap_code), 32'h0);
      rst = 1'b0;
      mie = 32'h03FF_0888;
      mstatus_mie = 1'b1;

      // 1: one-cycle TIM0 pulse
      plat_irq = 10'h004; tick();
      chk("t1_mip_n1", mip, 32'h0004_0000);
      chk("t1_req_n1", 32'(trap_req), 32'h0);
      plat_irq = '0; tick();
      chk("t1_req_n2", 32'(trap_req), 32'h1);
      chk("t1_code_n2", 32'(trap_code), 32'd18);
`ifdef IRQ_CTRL_EDGE_EN
      chk("t1_mip_n2", mip, 32'h0004_0000);
`else
      chk("t1_mip_n2", mip, 32'h0);
`endif
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      chk("t1_req_ack", 32'(trap_req), 32'h0);
      chk("t1_mip_ack", mip, 32'h0);
      tick();
      chk("t1_req_hold", 32'(trap_req), 32'h0);

      // 2: MTI beats GPIOA0, GPIOA0 follows after HOLD
      mtip = 1'b1; plat_irq = 10'h010; tick();
      chk("t2_mip", mip, 32'h0010_0080);
      tick();
      chk("t2_req_a", 32'(trap_req), 32'h1);
      chk("t2_code_a", 32'(trap_code), 32'd7);
      trap_ack = 1'b1; mtip = 1'b0; tick(); trap_ack = 1'b0;
      chk("t2_req_ack", 32'(trap_req), 32'h0);
      chk("t2_mip_ack", mip, 32'h0010_0000);
      tick();
      chk("t2_req_hold", 32'(trap_req), 32'h0);
      tick();
      chk("t2_req_b", 32'(trap_req), 32'h1);
      chk("t2_code_b", 32'(trap_code), 32'd20);
      trap_ack = 1'b1; plat_irq = '0; tick(); trap_ack = 1'b0;
      chk("t2_mip_done", mip, 32'h0);
      tick();

      // 3: withdrawal by masking mie.UART0RX
      plat_irq = 10'h001; tick();
      chk("t3_mip", mip, 32'h0001_0000);
      tick();
      chk("t3_req", 32'(trap_req), 32'h1);
      chk("t3_code", 32'(trap_code), 32'd16);
      mie = 32'h03FE_0888; tick();
      chk("t3_req_wd", 32'(trap_req), 32'h0);
      chk("t3_mip_wd", mip, 32'h0001_0000);
      tick();
      chk("t3_req_idle", 32'(trap_req), 32'h0);
      mie = 32'h03FF_0888; tick();
      chk("t4_req", 32'(trap_req), 32'h1);
      chk("t4_code", 32'(trap_code), 32'd16);

      // 4: re-arrival coincident with ack
`ifdef IRQ_CTRL_EDGE_EN
      plat_irq = '0; tick();
      chk("t4_req_latched", 32'(trap_req), 32'h1);
      plat_irq = 10'h001;
`endif
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      chk("t4_mip_ack", mip, 32'h0001_0000);
      chk("t4_req_ack", 32'(trap_req), 32'h0);
      tick();
      chk("t4_req_hold", 32'(trap_req), 32'h0);
      tick();
      chk("t4_req_again", 32'(trap_req), 32'h1);
      chk("t4_code_again", 32'(trap_code), 32'd16);
      trap_ack = 1'b1; plat_irq = '0; tick(); trap_ack = 1'b0;
      chk("t4_mip_done", mip, 32'h0);
      tick();

      // 5: global disable, stray ack, mip_clr
      mstatus_mie = 1'b0; plat_irq = 10'h201; tick();
      chk("t5_mip", mip, 32'h0201_0000);
      chk("t5_req", 32'(trap_req), 32'h0);
`ifdef IRQ_CTRL_EDGE_EN
      plat_irq = '0;
`endif
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      chk("t5_mip_stray_ack", mip, 32'h0201_0000);
      chk("t5_req_off", 32'(trap_req), 32'h0);
      mip_clr = 1'b1; mip_clr_mask = 32'h0200_0000; tick(); mip_clr = 1'b0;
`ifdef IRQ_CTRL_EDGE_EN
      chk("t5_mip_clr", mip, 32'h0001_0000);
`else
      chk("t5_mip_clr", mip, 32'h0201_0000);
`endif
      plat_irq = '0; tick();
`ifdef IRQ_CTRL_EDGE_EN
      chk("t5_mip_drop", mip, 32'h0001_0000);
`else
      chk("t5_mip_drop", mip, 32'h0);
`endif

      // 6: reset while requesting
      plat_irq = 10'h001; mstatus_mie = 1'b1; tick(); tick();
      chk("t6_req", 32'(trap_req), 32'h1);
      chk("t6_code", 32'(trap_code), 32'd16);
      rst = 1'b1; tick();
      chk("t6_req_rst", 32'(trap_req), 32'h0);
      chk("t6_mip_rst", mip, 32'h0);
      chk("t6_code_rst", 32'(trap_code), 32'h0);
      rst = 1'b0; plat_irq = '0; tick();

      // 7: MEI > MSI > MTI
      meip = 1'b1; msip = 1'b1; mtip = 1'b1; tick();
      chk("t7_mip", mip, 32'h0000_0888);
      tick();
      chk("t7_req_mei", 32'(trap_req), 32'h1);
      chk("t7_code_mei", 32'(trap_code), 32'd11);
      meip = 1'b0; trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      tick(); tick();
      chk("t7_req_msi", 32'(trap_req), 32'h1);
      chk("t7_code_msi", 32'(trap_code), 32'd3);
      msip = 1'b0; mtip = 1'b0; trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      tick(); tick();
      chk("t7_req_end", 32'(trap_req), 32'h0);
      chk("t7_mip_end", mip, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
